// File: rtl/rsc2_llr_demap.sv
// QPSK soft demapper: rounds/saturates I/Q to symmetric LLRs, tracks sop/eop framing
// and reports per-frame length, saturation count and framing errors. Two-stage pipeline.

module rsc2_llr_quant #(
    parameter int pIDAT_W = 16,
    parameter int pLLR_W  = 5,
    parameter int pSHIFT  = 7
) (
    input  logic [pIDAT_W-1:0] idat,
    output logic [pLLR_W-1:0]  ollr,
    output logic               osat
);
    localparam int W = pIDAT_W + 1;
    localparam logic signed [W-1:0] LMAX = W'((2**(pLLR_W-1)) - 1);
    localparam logic signed [W-1:0] LMIN = -LMAX;
    localparam logic signed [W-1:0] HALF = W'(2**(pSHIFT-1));

    logic signed [W-1:0] sum, rnd;

    // one extra bit of headroom so the rounding offset can never wrap
    assign sum = $signed({idat[pIDAT_W-1], idat}) + HALF;
    assign rnd = sum >>> pSHIFT;

    always_comb begin
        osat = 1'b0;
        ollr = rnd[pLLR_W-1:0];
        if (rnd > LMAX) begin
            ollr = LMAX[pLLR_W-1:0];
            osat = 1'b1;
        end else if (rnd < LMIN) begin
            ollr = LMIN[pLLR_W-1:0];
            osat = 1'b1;
        end
    end
endmodule

module rsc2_llr_demap #(
    parameter int pIDAT_W  = 16,
    parameter int pLLR_W   = 5,
    parameter int pSHIFT   = 7,
    parameter int pMAX_LEN = 4096
) (
    input  logic                           iclk,
    input  logic                           ireset,
    input  logic                           iclkena,
    input  logic                           isop,
    input  logic                           ieop,
    input  logic                           ival,
    input  logic [pIDAT_W-1:0]             idat_re,
    input  logic [pIDAT_W-1:0]             idat_im,
    output logic                           osop,
    output logic                           oeop,
    output logic                           oval,
    output logic [pLLR_W-1:0]              oLLR_re,
    output logic [pLLR_W-1:0]              oLLR_im,
    output logic                           osat,
    output logic                           odrop,
    output logic [$clog2(pMAX_LEN+1)-1:0]  ofrm_len,
    output logic [$clog2(pMAX_LEN+1)-1:0]  ofrm_nsat,
    output logic                           ofrm_err
);
    localparam int CW = $clog2(pMAX_LEN+1);
    localparam logic [CW-1:0] MAXC = CW'(pMAX_LEN);

    typedef enum logic {IDLE, FRAME} state_t;

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic                   drop;
        logic                   sat;
        logic                   err;
        logic [CW-1:0]          len;
        logic [CW-1:0]          nsat;
        logic [1:0][pLLR_W-1:0] llr;
    } stg_t;

    logic [1:0][pIDAT_W-1:0] q_dat;
    logic [1:0][pLLR_W-1:0]  q_llr;
    logic [1:0]              q_sat;
    logic                    sat;

    assign q_dat = {idat_im, idat_re};
    assign sat   = |q_sat;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        rsc2_llr_quant #(.pIDAT_W(pIDAT_W), .pLLR_W(pLLR_W), .pSHIFT(pSHIFT)) u_quant (
            .idat (q_dat[g]),
            .ollr (q_llr[g]),
            .osat (q_sat[g])
        );
    end

    state_t        state, nxt_state;
    logic [CW-1:0] len, nxt_len, nsat, nxt_nsat;
    logic          ovf, nxt_ovf, acc;
    stg_t          s1_d, s1_q;
    logic [1:0]    vld_pipe;

    always_comb begin
        nxt_state = state;
        nxt_len   = len;
        nxt_nsat  = nsat;
        nxt_ovf   = ovf;
        acc       = 1'b0;
        s1_d      = '0;
        s1_d.llr  = q_llr;
        s1_d.sat  = sat;
        if (ival) begin
            if (isop) begin
                // a sop inside a frame aborts it; the new frame starts regardless
                acc       = 1'b1;
                s1_d.sop  = 1'b1;
                s1_d.err  = (state == FRAME);
                s1_d.eop  = ieop;
                nxt_len   = CW'(1);
                nxt_nsat  = CW'(sat);
                nxt_ovf   = 1'b0;
                nxt_state = ieop ? IDLE : FRAME;
            end else if (state == IDLE) begin
                s1_d.drop = 1'b1;
            end else begin
                acc      = 1'b1;
                nxt_len  = (len == MAXC) ? len : len + CW'(1);
                nxt_ovf  = ovf | (len == MAXC);
                nxt_nsat = (nsat == MAXC) ? nsat : nsat + CW'(sat);
                if (ieop) begin
                    s1_d.eop  = 1'b1;
                    s1_d.err  = nxt_ovf;
                    nxt_state = IDLE;
                end
            end
        end
        s1_d.len  = nxt_len;
        s1_d.nsat = nxt_nsat;
    end

    assign oval = vld_pipe[1];

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state     <= IDLE;
            len       <= '0;
            nsat      <= '0;
            ovf       <= 1'b0;
            vld_pipe  <= '0;
            s1_q      <= '0;
            osop      <= 1'b0;
            oeop      <= 1'b0;
            odrop     <= 1'b0;
            osat      <= 1'b0;
            ofrm_err  <= 1'b0;
            oLLR_re   <= '0;
            oLLR_im   <= '0;
            ofrm_len  <= '0;
            ofrm_nsat <= '0;
        end else if (iclkena) begin
            state    <= nxt_state;
            len      <= nxt_len;
            nsat     <= nxt_nsat;
            ovf      <= nxt_ovf;
            vld_pipe <= {vld_pipe[0], acc};
            s1_q     <= s1_d;
            osop     <= s1_q.sop;
            oeop     <= s1_q.eop;
            odrop    <= s1_q.drop;
            osat     <= vld_pipe[0] & s1_q.sat;
            ofrm_err <= s1_q.err;
            if (vld_pipe[0]) begin
                oLLR_re   <= s1_q.llr[0];
                oLLR_im   <= s1_q.llr[1];
                ofrm_len  <= s1_q.len;
                ofrm_nsat <= s1_q.nsat;
            end
        end
    end
endmodule

// File: tb/tb_rsc2_llr_demap.sv
// Scoreboard bench for rsc2_llr_demap: directed frames push hand-computed expectations,
// an independent monitor pops and compares whenever the DUT presents a sample or drop.

module tb_rsc2_llr_demap;
    localparam int IW = 16, LW = 5, SH = 7, ML = 4;
    localparam int CW = $clog2(ML+1);

    logic iclk = 0, ireset = 1, iclkena = 0, isop = 0, ieop = 0, ival = 0;
    logic [IW-1:0] idat_re = '0, idat_im = '0;
    logic osop, oeop, oval, osat, odrop, ofrm_err;
    logic [LW-1:0] oLLR_re, oLLR_im;
    logic [CW-1:0] ofrm_len, ofrm_nsat;

    rsc2_llr_demap #(.pIDAT_W(IW), .pLLR_W(LW), .pSHIFT(SH), .pMAX_LEN(ML)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ieop(ieop),
        .ival(ival), .idat_re(idat_re), .idat_im(idat_im), .osop(osop), .oeop(oeop),
        .oval(oval), .oLLR_re(oLLR_re), .oLLR_im(oLLR_im), .osat(osat), .odrop(odrop),
        .ofrm_len(ofrm_len), .ofrm_nsat(ofrm_nsat), .ofrm_err(ofrm_err)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic drop, sop, eop, err, sat;
        logic [LW-1:0] re, im;
        logic [CW-1:0] len, nsat;
    } exp_t;

    typedef logic [6+2*LW+2*CW-1:0] vec_t;

    exp_t sb[$];
    int   nchk = 0, nerr = 0;
    logic toggle = 0;
    logic upd = 0;

    // outputs only change on edges that were enabled and not in reset
    always @(posedge iclk) upd <= iclkena && !ireset;

    always @(negedge iclk) begin
        if (upd && (oval || odrop)) begin
            nchk++;
            if (sb.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_output: oval=%0b odrop=%0b with empty scoreboard", oval, odrop);
            end else begin
                exp_t e;
                vec_t act, expv, mask;
                e = sb.pop_front();
                act  = {oval, odrop, osop, oeop, ofrm_err, osat, oLLR_re, oLLR_im,
                        oeop ? ofrm_len : CW'(0), oeop ? ofrm_nsat : CW'(0)};
                expv = {~e.drop, e.drop, e.sop, e.eop, e.err, e.sat, e.re, e.im,
                        e.eop ? e.len : CW'(0), e.eop ? e.nsat : CW'(0)};
                mask = e.drop ? {6'h3F, {(2*LW+2*CW){1'b0}}} : '1;
                if ((act & mask) !== (expv & mask)) begin
                    nerr++;
                    $display("FAIL output_%0d: actual %h required %h (val,drop,sop,eop,err,sat,re,im,len,nsat)",
                             nchk, act & mask, expv & mask);
                end
            end
        end
    end

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic tick();
        iclkena = 1;
        step();
        if (toggle) begin
            iclkena = 0;
            step();
            iclkena = 1;
        end
    endtask

    task automatic drive(input logic s, e, input int re, im);
        isop = s; ieop = e; ival = 1;
        idat_re = IW'(re); idat_im = IW'(im);
        tick();
        ival = 0; isop = 0; ieop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic s, e, input int re, im, input int ere, eim,
                        input logic esat, eerr, input int elen, ensat);
        exp_t x;
        x.drop = 0; x.sop = s; x.eop = e; x.err = eerr; x.sat = esat;
        x.re = LW'(ere); x.im = LW'(eim); x.len = CW'(elen); x.nsat = CW'(ensat);
        sb.push_back(x);
        drive(s, e, re, im);
    endtask

    task automatic orphan(input logic e, input int re, im);
        exp_t x;
        x.drop = 1; x.sop = 0; x.eop = 0; x.err = 0; x.sat = 0;
        x.re = '0; x.im = '0; x.len = '0; x.nsat = '0;
        sb.push_back(x);
        drive(1'b0, e, re, im);
    endtask

    task automatic chk_zero(input string name);
        vec_t act;
        act = {oval, odrop, osop, oeop, ofrm_err, osat, oLLR_re, oLLR_im, ofrm_len, ofrm_nsat};
        nchk++;
        if (act !== '0) begin
            nerr++;
            $display("FAIL %s: outputs %h required 0", name, act);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ireset = 1;
        step(); step(); step();
        chk_zero("reset_state");
        ireset = 0;
        idle(2);

        // 4-symbol frame: exactly pMAX_LEN long, Q saturates every symbol
        send(1, 0, 1024, 2047,   8, 15, 1, 0, 0, 0);
        send(0, 0, -1024, 2047, -8, 15, 1, 0, 0, 0);
        send(0, 0, 0, 2047,      0, 15, 1, 0, 0, 0);
        send(0, 1, -64, 2047,    0, 15, 1, 0, 4, 4);
        idle(2);

        // single-symbol frame
        send(1, 1, -2047, 63, -15, 0, 1, 0, 1, 1);
        idle(2);

        // orphans dropped, then a 2-symbol frame
        orphan(0, 500, 500);
        orphan(0, -500, 1);
        orphan(1, 7, 7);
        send(1, 0, 100, -100, 1, -1, 0, 0, 0, 0);
        send(0, 1, 200, 0,    2, 0,  0, 0, 2, 0);
        idle(2);

        // sop re-asserted on symbol 3 aborts the first frame
        send(1, 0, 300, -300, 2, -2, 0, 0, 0, 0);
        send(0, 0, 0, 0,      0, 0,  0, 0, 0, 0);
        send(1, 0, -1, 1,     0, 0,  0, 1, 0, 0);
        send(0, 0, 127, -128, 1, -1, 0, 0, 0, 0);
        send(0, 1, -65, 64,  -1, 1,  0, 0, 3, 0);
        idle(2);

        // 6 symbols past pMAX_LEN=4, with rounding/saturation boundaries
        send(1, 0, 1983, -1984,    15, -15, 0, 0, 0, 0);
        send(0, 0, 1984, -1985,    15, -15, 1, 0, 0, 0);
        send(0, 0, 32767, -32768,  15, -15, 1, 0, 0, 0);
        send(0, 0, 0, 0,            0, 0,   0, 0, 0, 0);
        send(0, 0, 2047, 0,        15, 0,   1, 0, 0, 0);
        send(0, 1, 0, 0,            0, 0,   0, 1, 4, 3);
        idle(2);

        // nsat saturates at pMAX_LEN
        for (int i = 0; i < 4; i++) send(i == 0, 0, 0, 2047, 0, 15, 1, 0, 0, 0);
        send(0, 1, 0, 2047, 0, 15, 1, 1, 4, 4);
        idle(2);

        // clock enable toggling, reset mid-frame, then recovery
        toggle = 1;
        send(1, 0, 1024, -1024, 8, -8, 0, 0, 0, 0);
        send(0, 0, 512, -512,   4, -4, 0, 0, 0, 0);
        idle(3);
        ireset = 1; iclkena = 1;
        step();
        ireset = 0;
        chk_zero("reset_mid_frame");
        orphan(1, 100, 100);
        send(1, 0, 64, -64,   1, 0, 0, 0, 0, 0);
        send(0, 1, -129, 129, -1, 1, 0, 0, 2, 0);
        idle(4);
        toggle = 0;
        idle(4);

        nchk++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL scoreboard_drain: %0d outputs missing, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/rsc2_llr_demap.md
Name: rsc2_llr_demap

Overview:
- Synthesizable QPSK soft demapper and quantizer feeding the rsc2_dec iLLR input.
- Takes normalized, gain-controlled complex samples in which the QPSK reference point is ±1024. Rounds and saturates each I/Q component to a pLLR_W-bit symmetric LLR.
- Checks frame framing (sop/eop) and reports per-frame length, saturation count and framing errors, replacing the behavioural scaling path used in benches.

Parameters:
- pIDAT_W, 16: input sample width, signed two's complement.
- pLLR_W, 5: output LLR width, signed; {5.3} at default.
- pSHIFT, 7: LSBs dropped. Default selects bits [11:7] relative to ref 1024.
- pMAX_LEN, 4096: maximum symbols per frame. The length counter is $clog2(pMAX_LEN+1) bits wide.

Ports:
- iclk, in, 1: clock.
- ireset, in, 1: synchronous active-high reset.
- iclkena, in, 1: clock enable. All state holds when low.
- isop, in, 1: first symbol of frame, qualified by ival.
- ieop, in, 1: last symbol of frame, qualified by ival.
- ival, in, 1: input sample valid.
- idat_re, in, pIDAT_W: I component, signed.
- idat_im, in, pIDAT_W: Q component, signed.
- osop, out, 1: start of frame.
- oeop, out, 1: end of frame.
- oval, out, 1: LLR valid.
- oLLR_re, out, pLLR_W: I LLR, signed.
- oLLR_im, out, pLLR_W: Q LLR, signed.
- osat, out, 1: either component of this sample saturated.
- odrop, out, 1: one-cycle pulse; the input sample was discarded (orphan).
- ofrm_len, out, $clog2(pMAX_LEN+1): symbol count of the frame; valid with oeop.
- ofrm_nsat, out, $clog2(pMAX_LEN+1): saturated symbols in the frame; valid with oeop.
- ofrm_err, out, 1: framing error, qualified by oeop or osop.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Counters clear.
  - Pipeline valids clear.
- Reset mid-frame discards the frame. No oeop is emitted for it.
- Latency: exactly 2 enabled cycles from ival to oval. osop, oeop and odrop are aligned to the same stage. iclkena low freezes both stages and the FSM.
- Arithmetic, per component:
  - r = (x + 2^(pSHIFT-1)) >>> pSHIFT, evaluated in pIDAT_W+1 bits with no overflow.
  - Saturate to ±(2^(pLLR_W-1)-1). The most-negative code is never produced.
  - Set osat if either component clipped.
- Stage 1 registers the rounded and saturated values plus control. Stage 2 drives the outputs.
- FSM states: IDLE, FRAME.
- In IDLE:
  - ival&isop&!ieop: go to FRAME; len=1; nsat=sat.
  - ival&isop&ieop: single-symbol frame. Emit osop and oeop together with ofrm_len=1. Stay in IDLE.
  - ival&!isop: orphan sample. Discard it (oval=0) and pulse odrop.
- In FRAME:
  - ival&!isop&!ieop: len++; nsat+=sat.
  - ival&ieop: emit oeop with the final len/nsat; go to IDLE. ofrm_err=1 if len exceeded pMAX_LEN.
  - ival&isop (sop inside frame): the previous frame is aborted. Emit osop for the new frame with ofrm_err=1 (previous frame had no eop). Counters restart at 1. Stay in FRAME. If ieop is also set, treat it as a single-symbol frame and go to IDLE.
- Length overflow:
  - The len counter saturates at pMAX_LEN.
  - Samples beyond pMAX_LEN are still forwarded.
  - ofrm_err is asserted at eop.
- nsat saturates at pMAX_LEN.
- ofrm_err must be 0 whenever both osop and oeop are 0.
- ival low: outputs oval=osop=oeop=odrop=0. LLR outputs hold their last value.

Test Plan:
- pLLR_W=5, pSHIFT=7, 4-symbol frame with I={1024,-1024,0,-64} and Q=2047 → after 2 cycles:
  - oLLR_re={8,-8,0,0}, oLLR_im=15.
  - osat=1 on all four.
  - oeop on the 4th symbol with ofrm_len=4, ofrm_nsat=4, ofrm_err=0.
- Single symbol I=-2047, Q=+63, isop=ieop=1 → oLLR_re=-15, oLLR_im=0, osat=1, osop=oeop=1, ofrm_len=1.
- 3 orphan samples (no sop) then a 2-symbol frame → three odrop pulses with oval=0, then normal frame output with ofrm_len=2.
- Frame of 5 symbols, sop re-asserted on the 3rd → osop on symbol 3 with ofrm_err=1; final oeop reports ofrm_len=3, ofrm_err=0.
- pMAX_LEN=4, 6-symbol frame → all 6 symbols forwarded; oeop with ofrm_len=4, ofrm_err=1.
- iclkena toggled 1/0 every cycle during a frame, plus ireset asserted mid-frame → outputs are identical to the enabled run stretched ×2. After reset, all outputs are 0 and the next sop frame decodes correctly.
